// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator between the CPU pipeline and the
// byte-addressed data RAM. It accepts one request at a time, rejects
// misaligned, out-of-range and malformed requests without touching memory,
// drives the RAM port, and returns load data (or the AMO old value) over a
// valid/ready response channel.
//
// Optional feature: define LSU_AMO_EN to build the word AMO read-modify-write
// path (AMO_WR state). Without it, req_op=10 is answered with an error.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake (ready iff IDLE)
//   req_op, req_funct3,
//   req_amo_fn, req_addr,
//   req_wdata                 request fields
//   rsp_valid/rsp_ready       response handshake
//   rsp_data, rsp_err         load result / AMO old value, error flag
//   mem_addr, mem_din,
//   mem_we, mem_u_b_h_w       RAM port (RAM writes on negedge)
//   mem_dout                  RAM combinational read data, already extended
module lsu_mem_master #(
    parameter int unsigned ADDR_BITS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [2:0]  req_funct3,
    input  logic [2:0]  req_amo_fn,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_we,
    output logic [2:0]  mem_u_b_h_w,
    input  logic [31:0] mem_dout
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_AMO   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

`ifdef LSU_AMO_EN
    typedef enum logic [1:0] {IDLE, ACCESS, AMO_WR, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

    state_t      state, state_d;
    logic [1:0]  op_q;
    logic        req_err;
    logic        accept;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && (state == IDLE);

    // Request legality check on the raw request fields.
    always_comb begin
        req_err = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            req_err = 1'b1;
        if (req_op == OP_STORE && req_funct3[2])
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if ((req_addr >> ADDR_BITS) != 32'd0)
            req_err = 1'b1;
        if (req_op == OP_RSVD)
            req_err = 1'b1;
`ifdef LSU_AMO_EN
        if (req_op == OP_AMO && (req_funct3 != 3'b010 || req_amo_fn > 3'b100))
            req_err = 1'b1;
`else
        // amo_fn is still inspected so the port is not left dangling; any AMO
        // is rejected regardless.
        if (req_op == OP_AMO || req_amo_fn > 3'b100 && req_op == OP_AMO)
            req_err = 1'b1;
`endif
    end

`ifdef LSU_AMO_EN
    logic [2:0]  amo_fn_q;
    logic [31:0] amo_result;

    // mem_din still holds the operand during ACCESS; old value is mem_dout.
    always_comb begin
        amo_result = mem_din;
        case (amo_fn_q)
            3'b000:  amo_result = mem_din;
            3'b001:  amo_result = mem_dout + mem_din;
            3'b010:  amo_result = mem_dout ^ mem_din;
            3'b011:  amo_result = mem_dout & mem_din;
            3'b100:  amo_result = mem_dout | mem_din;
            default: amo_result = mem_din;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next state and write enable, decoded from registered state only.
    always_comb begin
        state_d = state;
        mem_we  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) state_d = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_we  = (op_q == OP_STORE);
`ifdef LSU_AMO_EN
                state_d = (op_q == OP_AMO) ? AMO_WR : RESP;
`else
                state_d = RESP;
`endif
            end
`ifdef LSU_AMO_EN
            AMO_WR: begin
                mem_we  = 1'b1;
                state_d = RESP;
            end
`endif
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= OP_LOAD;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_u_b_h_w <= '0;
`ifdef LSU_AMO_EN
            amo_fn_q    <= '0;
`endif
        end else begin
            if (accept) begin
                op_q     <= req_op;
                rsp_data <= '0;
                rsp_err  <= req_err;
`ifdef LSU_AMO_EN
                amo_fn_q <= req_amo_fn;
`endif
                // Rejected requests leave the RAM port untouched.
                if (!req_err) begin
                    mem_addr    <= req_addr;
                    mem_din     <= req_wdata;
                    mem_u_b_h_w <= req_funct3;
                end
            end
            if (state == ACCESS && op_q != OP_STORE) begin
                rsp_data <= mem_dout;
`ifdef LSU_AMO_EN
                if (op_q == OP_AMO) mem_din <= amo_result;
`endif
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master with a behavioural byte RAM that
// writes on negedge and returns sign/zero-extended read data combinationally.
// Expected responses are queued by the stimulus and checked by a monitor.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [2:0]  req_funct3 = '0;
    logic [2:0]  req_amo_fn = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic [2:0]  mem_u_b_h_w;
    logic [31:0] mem_dout;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb_data[$];
    logic        sb_err[$];

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_BITS(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_funct3(req_funct3), .req_amo_fn(req_amo_fn),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_u_b_h_w(mem_u_b_h_w), .mem_dout(mem_dout)
    );

    // Behavioural RAM, 128 bytes, little-endian.
    logic [7:0] ram [128];
    logic [6:0] a0, a1, a2, a3;
    assign a0 = mem_addr[6:0];
    assign a1 = a0 + 7'd1;
    assign a2 = a0 + 7'd2;
    assign a3 = a0 + 7'd3;

    initial for (int i = 0; i < 128; i++) ram[i] = 8'h00;

    always @(negedge clk) begin
        if (mem_we) begin
            ram[a0] <= mem_din[7:0];
            if (mem_u_b_h_w[1:0] != 2'b00) ram[a1] <= mem_din[15:8];
            if (mem_u_b_h_w[1:0] == 2'b10) begin
                ram[a2] <= mem_din[23:16];
                ram[a3] <= mem_din[31:24];
            end
        end
    end

    always_comb begin
        case (mem_u_b_h_w)
            3'b000:  mem_dout = {{24{ram[a0][7]}}, ram[a0]};
            3'b001:  mem_dout = {{16{ram[a1][7]}}, ram[a1], ram[a0]};
            3'b100:  mem_dout = {24'd0, ram[a0]};
            3'b101:  mem_dout = {16'd0, ram[a1], ram[a0]};
            default: mem_dout = {ram[a3], ram[a2], ram[a1], ram[a0]};
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed response handshake is checked against the queue.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_data.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                chk("rsp_data", rsp_data, sb_data.pop_front());
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, sb_err.pop_front()});
            end
        end
    end

    // Issue one request (called at posedge+1 with rsp_ready high) and check
    // latency, mem_we pulse count and return to IDLE after the handshake.
    task automatic do_req(input logic [1:0] op, input logic [2:0] f3, input logic [2:0] fn,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] ed, input logic ee, input int lat, input int wes);
        int cyc;
        int we_n;
        cyc  = 1;
        we_n = 0;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_funct3 = f3; req_amo_fn = fn;
        req_addr = a; req_wdata = wd;
        sb_data.push_back(ed);
        sb_err.push_back(ee);
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!rsp_valid && cyc < 20) begin
            if (mem_we) we_n++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("mem_we_cycles", we_n, wes);
        @(posedge clk); #1;
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        chk("rst_mem_size", {29'd0, mem_u_b_h_w}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // op, funct3, amo_fn, addr, wdata, exp data, exp err, latency, mem_we cycles
        do_req(2'b01, 3'b010, 3'd0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1);
        do_req(2'b00, 3'b010, 3'd0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0);
        do_req(2'b01, 3'b000, 3'd0, 32'h21, 32'h80,       32'h0,        1'b0, 2, 1);
        do_req(2'b00, 3'b000, 3'd0, 32'h21, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0);
        do_req(2'b00, 3'b100, 3'd0, 32'h21, 32'h0,        32'h00000080, 1'b0, 2, 0);
        do_req(2'b01, 3'b001, 3'd0, 32'h22, 32'h8001,     32'h0,        1'b0, 2, 1);
        do_req(2'b00, 3'b001, 3'd0, 32'h22, 32'h0,        32'hFFFF8001, 1'b0, 2, 0);
        do_req(2'b00, 3'b101, 3'd0, 32'h22, 32'h0,        32'h00008001, 1'b0, 2, 0);
        // Errors: misaligned, out of range, bad sizes, reserved op.
        do_req(2'b00, 3'b010, 3'd0, 32'h13, 32'h0,        32'h0,        1'b1, 1, 0);
        do_req(2'b01, 3'b010, 3'd0, 32'h80, 32'h11111111, 32'h0,        1'b1, 1, 0);
        do_req(2'b00, 3'b010, 3'd0, 32'h00, 32'h0,        32'h0,        1'b0, 2, 0);
        do_req(2'b00, 3'b001, 3'd0, 32'h23, 32'h0,        32'h0,        1'b1, 1, 0);
        do_req(2'b01, 3'b100, 3'd0, 32'h24, 32'h55,       32'h0,        1'b1, 1, 0);
        do_req(2'b00, 3'b011, 3'd0, 32'h20, 32'h0,        32'h0,        1'b1, 1, 0);
        do_req(2'b11, 3'b010, 3'd0, 32'h20, 32'h0,        32'h0,        1'b1, 1, 0);
        do_req(2'b00, 3'b000, 3'd0, 32'h7F, 32'h0,        32'h0,        1'b0, 2, 0);
        do_req(2'b00, 3'b000, 3'd0, 32'h100, 32'h0,       32'h0,        1'b1, 1, 0);

        // AMO sequence on word 0x40.
        do_req(2'b01, 3'b010, 3'd0, 32'h40, 32'd5,        32'h0,        1'b0, 2, 1);
`ifdef LSU_AMO_EN
        do_req(2'b10, 3'b010, 3'd1, 32'h40, 32'hFFFFFFFF, 32'd5,        1'b0, 3, 1);
        do_req(2'b00, 3'b010, 3'd0, 32'h40, 32'h0,        32'd4,        1'b0, 2, 0);
        do_req(2'b10, 3'b010, 3'd0, 32'h40, 32'h1234,     32'd4,        1'b0, 3, 1);
        do_req(2'b10, 3'b010, 3'd4, 32'h40, 32'h00F0,     32'h1234,     1'b0, 3, 1);
        do_req(2'b10, 3'b010, 3'd2, 32'h40, 32'h0FF0,     32'h12F4,     1'b0, 3, 1);
        do_req(2'b10, 3'b010, 3'd3, 32'h40, 32'hF00F,     32'h1D04,     1'b0, 3, 1);
        do_req(2'b00, 3'b010, 3'd0, 32'h40, 32'h0,        32'h1004,     1'b0, 2, 0);
        do_req(2'b10, 3'b000, 3'd1, 32'h40, 32'h1,        32'h0,        1'b1, 1, 0);
        do_req(2'b10, 3'b010, 3'd5, 32'h40, 32'h1,        32'h0,        1'b1, 1, 0);
`else
        do_req(2'b10, 3'b010, 3'd1, 32'h40, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0);
        do_req(2'b00, 3'b010, 3'd0, 32'h40, 32'h0,        32'd5,        1'b0, 2, 0);
`endif

        // Back-pressure: response held for 4 cycles with rsp_ready low.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'b00; req_funct3 = 3'b010; req_addr = 32'h10;
        sb_data.push_back(32'hDEADBEEF);
        sb_err.push_back(1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_data", rsp_data, 32'hDEADBEEF);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_req_ready", {31'd0, req_ready}, 32'd1);
        chk("release_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset during the ACCESS cycle of a store must suppress the write.
        req_valid = 1'b1; req_op = 2'b01; req_funct3 = 3'b010;
        req_addr = 32'h08; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("access_mem_we", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        chk("arst_mem_din", mem_din, 32'd0);
        chk("arst_mem_size", {29'd0, mem_u_b_h_w}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_req(2'b00, 3'b010, 3'd0, 32'h08, 32'h0,        32'h0,        1'b0, 2, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb_data.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
